add_pipe_gen: RTL and testbench

Parametrised, pipelined carry-propagate adder. Successor to the fixed 4-bit generate-based ripple adder. Splits a WIDTH-bit add into STAGES = WIDTH/SEG segments, one segment per pipeline stage, with the carry registered between stages. Uses a valid/ready handshake with full-pipeline stall, so it can sit inside streaming datapaths at one result per clock.

---
 rtl/add_pipe_gen_if.sv | 26 ++
 rtl/add_pipe_gen.sv | 96 +++++++++
 tb/tb_add_pipe_gen.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/add_pipe_gen_if.sv
// Streaming handshake bundle for add_pipe_gen: operands in on a/b/c_in, results out on sum/c_out/ovf.
// The slave modport is the adder side; the master modport is the producer/consumer side.
interface add_pipe_gen_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output a, b, c_in, in_valid, out_ready,
    input  in_ready, sum, c_out, ovf, out_valid
  );

  modport slave (
    input  a, b, c_in, in_valid, out_ready,
    output in_ready, sum, c_out, ovf, out_valid
  );
endinterface

// File: rtl/add_pipe_gen.sv
// Pipelined carry-propagate adder: one SEG-bit slice per stage, carry registered between stages.
// A single advance enable stalls every stage at once, so results leave in order at one per clock.
module add_pipe_gen #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input logic           clk,
  input logic           rst,
  add_pipe_gen_if.slave io
);
  localparam int STAGES = (SEG >= 1) ? WIDTH / SEG : 1;

  if (SEG < 1 || WIDTH < SEG || (WIDTH % SEG) != 0) begin : g_param_check
    $error("add_pipe_gen: WIDTH (%0d) must be a non-zero multiple of SEG (%0d)", WIDTH, SEG);
  end

  logic en;

  assign en          = io.out_ready || !io.out_valid;
  assign io.in_ready = en;

  // Stage k sees only the operand bits it has not consumed yet; its slice sits at bit 0.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int REM  = WIDTH - k * SEG;
    localparam int DONE = k * SEG;

    logic [REM-1:0]      a_i;
    logic [REM-1:0]      b_i;
    logic                c_i;
    logic                v_i;
    logic [SEG:0]        seg_sum;
    logic [DONE+SEG-1:0] s_n;
    logic                vld_q;
    logic                cy_q;
    logic [DONE+SEG-1:0] sum_q;

    if (k == 0) begin : g_head
      assign a_i = io.a;
      assign b_i = io.b;
      assign c_i = io.c_in;
      assign v_i = io.in_valid;
      assign s_n = seg_sum[SEG-1:0];
    end else begin : g_body
      assign a_i = g_stage[k-1].g_fwd.a_q;
      assign b_i = g_stage[k-1].g_fwd.b_q;
      assign c_i = g_stage[k-1].cy_q;
      assign v_i = g_stage[k-1].vld_q;
      assign s_n = {seg_sum[SEG-1:0], g_stage[k-1].sum_q};
    end

    assign seg_sum = {1'b0, a_i[SEG-1:0]} + {1'b0, b_i[SEG-1:0]} + {{SEG{1'b0}}, c_i};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        sum_q <= '0;
      end else if (en) begin
        vld_q <= v_i;
        cy_q  <= seg_sum[SEG];
        sum_q <= s_n;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [REM-SEG-1:0] a_q;
      logic [REM-SEG-1:0] b_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_i[REM-1:SEG];
          b_q <= b_i[REM-1:SEG];
        end
      end
    end else begin : g_last
      // Carry into the MSB is recovered from the MSB sum bit and the two MSB operand bits.
      logic cmsb_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cmsb_q <= 1'b0;
        end else if (en) begin
          cmsb_q <= seg_sum[SEG-1] ^ a_i[SEG-1] ^ b_i[SEG-1];
        end
      end
    end
  end

  assign io.out_valid = g_stage[STAGES-1].vld_q;
  assign io.sum       = g_stage[STAGES-1].sum_q;
  assign io.c_out     = g_stage[STAGES-1].cy_q;
  assign io.ovf       = g_stage[STAGES-1].g_last.cmsb_q ^ g_stage[STAGES-1].cy_q;
endmodule

// File: tb/tb_add_pipe_gen.sv
// Directed bench for add_pipe_gen: a 4-stage instance (SEG=4) and a single-stage instance (SEG=16).
// Inputs are driven and outputs sampled on the falling edge, away from the active rising edge.
module tb_add_pipe_gen;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  localparam logic [15:0] STREAM_SUM [8] = '{16'hF0F0, 16'h0202, 16'h1312, 16'h2424,
                                             16'h3534, 16'h4646, 16'h5756, 16'h6868};
  localparam logic        STREAM_C   [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  add_pipe_gen_if #(.WIDTH(16)) io4 ();
  add_pipe_gen_if #(.WIDTH(16)) io16 ();

  add_pipe_gen #(.WIDTH(16), .SEG(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .io  (io4.slave)
  );

  add_pipe_gen #(.WIDTH(16), .SEG(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .io  (io16.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    io4.a = '0;  io4.b = '0;  io4.c_in = 1'b0;  io4.in_valid = 1'b0;  io4.out_ready = 1'b1;
    io16.a = '0; io16.b = '0; io16.c_in = 1'b0; io16.in_valid = 1'b0; io16.out_ready = 1'b1;
    #2;
    vectors++; if (io4.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %b expected 0", io4.out_valid); end
    vectors++; if (io4.sum !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_sum: got %h expected 0000", io4.sum); end
    vectors++; if (io4.c_out !== 1'b0 || io4.ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_flags: got c_out=%b ovf=%b expected 0 0", io4.c_out, io4.ovf); end
    vectors++; if (io4.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b expected 1", io4.in_ready); end
    vectors++; if (io16.out_valid !== 1'b0 || io16.sum !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_seg16: got valid=%b sum=%h expected 0 0000", io16.out_valid, io16.sum); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_latency();
    int lat;
    io4.a = 16'h00FF; io4.b = 16'h0001; io4.c_in = 1'b0; io4.in_valid = 1'b1; io4.out_ready = 1'b1;
    tick();
    io4.in_valid = 1'b0;
    lat = 0;
    while (!io4.out_valid && lat < 10) begin
      tick();
      lat++;
    end
    vectors++; if (lat !== 3) begin miscompares++; $display("[TB] FAIL latency: got %0d extra edges expected 3", lat); end
    vectors++; if (io4.sum !== 16'h0100) begin miscompares++; $display("[TB] FAIL latency_sum: got %h expected 0100", io4.sum); end
    vectors++; if (io4.c_out !== 1'b0 || io4.ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL latency_flags: got c_out=%b ovf=%b expected 0 0", io4.c_out, io4.ovf); end
    tick();
    vectors++; if (io4.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL latency_single: got out_valid=%b expected 0", io4.out_valid); end
  endtask

  task automatic test_arith();
    logic [15:0] va [4] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h1234};
    logic [15:0] vb [4] = '{16'h0000, 16'h0001, 16'h8000, 16'h4321};
    logic        vc [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [15:0] es [4] = '{16'h0000, 16'h8000, 16'h0000, 16'h5555};
    logic        ec [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic        eo [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int lat;
    for (int i = 0; i < 4; i++) begin
      io4.a = va[i]; io4.b = vb[i]; io4.c_in = vc[i]; io4.in_valid = 1'b1;
      tick();
      io4.in_valid = 1'b0;
      lat = 0;
      while (!io4.out_valid && lat < 10) begin
        tick();
        lat++;
      end
      vectors++; if (io4.out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL arith%0d_valid: got %b expected 1", i, io4.out_valid); end
      vectors++; if (io4.sum !== es[i]) begin miscompares++; $display("[TB] FAIL arith%0d_sum: got %h expected %h", i, io4.sum, es[i]); end
      vectors++; if (io4.c_out !== ec[i]) begin miscompares++; $display("[TB] FAIL arith%0d_c_out: got %b expected %b", i, io4.c_out, ec[i]); end
      vectors++; if (io4.ovf !== eo[i]) begin miscompares++; $display("[TB] FAIL arith%0d_ovf: got %b expected %b", i, io4.ovf, eo[i]); end
      tick();
    end
  endtask

  task automatic test_stream(input bit stall);
    int  in_idx = 0;
    int  out_idx = 0;
    int  first = -1;
    int  last = -1;
    bit  in_fire;
    bit  out_fire;
    bit  stalled;
    for (int c = 0; c < 40 && out_idx < 8; c++) begin
      stalled = stall && c >= 6 && c <= 8;
      io4.out_ready = !stalled;
      if (in_idx < 8) begin
        io4.a = 16'(in_idx * 16'h1111); io4.b = 16'hF0F0; io4.c_in = in_idx[0]; io4.in_valid = 1'b1;
      end else begin
        io4.in_valid = 1'b0;
      end
      #1;
      if (stalled) begin
        vectors++; if (io4.in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_in_ready c%0d: got %b expected 0", c, io4.in_ready); end
        vectors++; if (io4.out_valid !== 1'b1 || io4.sum !== 16'h1312) begin miscompares++; $display("[TB] FAIL stall_hold c%0d: got valid=%b sum=%h expected 1 1312", c, io4.out_valid, io4.sum); end
      end
      in_fire  = io4.in_valid && io4.in_ready;
      out_fire = io4.out_valid && io4.out_ready;
      if (out_fire) begin
        vectors++; if (io4.sum !== STREAM_SUM[out_idx] || io4.c_out !== STREAM_C[out_idx]) begin miscompares++; $display("[TB] FAIL stream_item%0d: got sum=%h c_out=%b expected %h %b", out_idx, io4.sum, io4.c_out, STREAM_SUM[out_idx], STREAM_C[out_idx]); end
        if (first < 0) first = c;
        last = c;
        out_idx++;
      end
      @(posedge clk);
      if (in_fire) in_idx++;
      @(negedge clk);
    end
    io4.in_valid = 1'b0;
    io4.out_ready = 1'b1;
    vectors++; if (out_idx !== 8) begin miscompares++; $display("[TB] FAIL stream_count: got %0d items expected 8", out_idx); end
    vectors++; if (first !== 4) begin miscompares++; $display("[TB] FAIL stream_first: got cycle %0d expected 4", first); end
    vectors++; if (last !== (stall ? 14 : 11)) begin miscompares++; $display("[TB] FAIL stream_last: got cycle %0d expected %0d", last, stall ? 14 : 11); end
    tick();
  endtask

  task automatic test_reset_midflight();
    int lat;
    io4.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      io4.a = 16'(16'h1000 + k); io4.b = 16'h0234; io4.c_in = 1'b0; io4.in_valid = 1'b1;
      tick();
    end
    io4.in_valid = 1'b0;
    vectors++; if (io4.out_valid !== 1'b1 || io4.sum !== 16'h1234) begin miscompares++; $display("[TB] FAIL midflight_pre: got valid=%b sum=%h expected 1 1234", io4.out_valid, io4.sum); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (io4.out_valid !== 1'b0 || io4.sum !== 16'h0000) begin miscompares++; $display("[TB] FAIL midflight_clear: got valid=%b sum=%h expected 0 0000", io4.out_valid, io4.sum); end
    vectors++; if (io4.in_ready !== 1'b1 || io4.c_out !== 1'b0) begin miscompares++; $display("[TB] FAIL midflight_ready: got in_ready=%b c_out=%b expected 1 0", io4.in_ready, io4.c_out); end
    #1 rst = 1'b0;
    @(negedge clk);
    tick();
    vectors++; if (io4.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midflight_discard: got out_valid=%b expected 0", io4.out_valid); end
    io4.a = 16'h0003; io4.b = 16'h0007; io4.c_in = 1'b1; io4.in_valid = 1'b1;
    tick();
    io4.in_valid = 1'b0;
    lat = 0;
    while (!io4.out_valid && lat < 10) begin
      tick();
      lat++;
    end
    vectors++; if (lat !== 3) begin miscompares++; $display("[TB] FAIL midflight_latency: got %0d extra edges expected 3", lat); end
    vectors++; if (io4.sum !== 16'h000B) begin miscompares++; $display("[TB] FAIL midflight_sum: got %h expected 000b", io4.sum); end
    tick();
  endtask

  task automatic test_seg16();
    int lat;
    io16.a = 16'h00FF; io16.b = 16'h0001; io16.c_in = 1'b0; io16.in_valid = 1'b1; io16.out_ready = 1'b1;
    tick();
    io16.in_valid = 1'b0;
    lat = 0;
    while (!io16.out_valid && lat < 10) begin
      tick();
      lat++;
    end
    vectors++; if (lat !== 0) begin miscompares++; $display("[TB] FAIL seg16_latency: got %0d extra edges expected 0", lat); end
    vectors++; if (io16.sum !== 16'h0100 || io16.c_out !== 1'b0 || io16.ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL seg16_result: got sum=%h c_out=%b ovf=%b expected 0100 0 0", io16.sum, io16.c_out, io16.ovf); end
    tick();
    vectors++; if (io16.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL seg16_single: got out_valid=%b expected 0", io16.out_valid); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_latency();
    test_arith();
    test_stream(1'b0);
    test_stream(1'b1);
    test_reset_midflight();
    test_seg16();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
